// File: rtl/ex2_pkg.sv
// ex2_pkg: HI/LO operation encoding and EX2 FSM state shared by the EX2 stage files
package ex2_pkg;
  typedef enum logic [2:0] {
    OP_NONE, OP_MULT, OP_MADD, OP_MSUB, OP_MTHI, OP_MTLO, OP_MFHI, OP_MFLO
  } hilo_op_e;
  typedef enum logic {ST_IDLE, ST_ACC} state_e;
endpackage

// File: rtl/hilo_acc.sv
// hilo_acc: HI/LO registers with split-cycle MADD/MSUB accumulate (LO+carry on accept, HI on finish)
module hilo_acc
  import ex2_pkg::*;
#(
  parameter logic [31:0] HILO_RST = 32'h0
) (
  input  logic        Clock,
  input  logic        nReset,
  input  logic        wr,
  input  logic        fin,
  input  hilo_op_e    op,
  input  logic [63:0] product,
  input  logic [31:0] src_a,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] hi_nxt,
  output logic [31:0] lo_nxt
);
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [63:0] p_q, p_d;
  logic        c_q, c_d;
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    p_d  = p_q;
    c_d  = c_q;
    if (wr) begin
      case (op)
        OP_MULT: {hi_d, lo_d} = product;
        OP_MADD, OP_MSUB: begin
          p_d = (op == OP_MSUB) ? -product : product;
          {c_d, lo_d} = {1'b0, lo_q} + {1'b0, p_d[31:0]};
        end
        OP_MTHI: hi_d = src_a;
        OP_MTLO: lo_d = src_a;
        default: ;
      endcase
    end
    if (fin) hi_d = hi_q + p_q[63:32] + {31'b0, c_q};
  end
  always_ff @(posedge Clock) begin
    if (!nReset) begin
      hi_q <= HILO_RST;
      lo_q <= HILO_RST;
      p_q  <= '0;
      c_q  <= 1'b0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
      p_q  <= p_d;
      c_q  <= c_d;
    end
  end
  assign hi     = hi_q;
  assign lo     = lo_q;
  assign hi_nxt = hi_d;
  assign lo_nxt = lo_d;
endmodule

// File: rtl/ex2.sv
// ex2: second execute stage register with HI/LO unit; Stall holds, Flush kills capture, Busy during MADD/MSUB ACC
module ex2
  import ex2_pkg::*;
#(
  parameter logic [31:0] HILO_RST = 32'h0
) (
  input  logic        Clock,
  input  logic        nReset,
  input  logic        Stall,
  input  logic        Flush,
  input  logic        InValid,
  input  logic [2:0]  HiLoOp,
  input  logic [63:0] Product,
  input  logic [31:0] ResultIn,
  input  logic [31:0] SrcA,
  input  logic [4:0]  DestIn,
  input  logic        RegWriteIn,
  input  logic [3:0]  FlagsIn,
  output logic [31:0] Result,
  output logic [4:0]  Dest,
  output logic        RegWrite,
  output logic [3:0]  Flags,
  output logic        Valid,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);
  state_e      state_q, state_d;
  logic [31:0] result_q, result_d;
  logic [4:0]  dest_q, dest_d;
  logic [3:0]  flags_q, flags_d;
  logic        reg_write_q, reg_write_d, valid_q, valid_d, rw_pend_q, rw_pend_d;
  logic [31:0] hi_nxt, lo_nxt;
  hilo_op_e    op;
  logic        busy, wr, fin, is_mac;
  assign op     = hilo_op_e'(HiLoOp);
  assign busy   = state_q == ST_ACC;
  assign wr     = InValid && !Flush && !Stall && !busy;
  assign fin    = busy && !Stall;
  assign is_mac = op == OP_MADD || op == OP_MSUB;
  hilo_acc #(.HILO_RST(HILO_RST)) u_hilo (
    .Clock(Clock), .nReset(nReset), .wr(wr), .fin(fin), .op(op),
    .product(Product), .src_a(SrcA), .hi(HI), .lo(LO), .hi_nxt(hi_nxt), .lo_nxt(lo_nxt)
  );
  always_comb begin
    state_d     = state_q;
    result_d    = result_q;
    dest_d      = dest_q;
    flags_d     = flags_q;
    reg_write_d = reg_write_q;
    valid_d     = valid_q;
    rw_pend_d   = rw_pend_q;
    if (fin) begin
      state_d     = ST_IDLE;
      valid_d     = 1'b1;
      reg_write_d = rw_pend_q;
    end else if (!Stall && !busy) begin
      state_d     = (wr && is_mac) ? ST_ACC : ST_IDLE;
      result_d    = (op == OP_MFHI) ? hi_nxt : (op == OP_MFLO) ? lo_nxt : ResultIn;
      dest_d      = DestIn;
      flags_d     = FlagsIn;
      valid_d     = wr && !is_mac;
      reg_write_d = wr && !is_mac && RegWriteIn;
      rw_pend_d   = RegWriteIn;
    end
  end
  always_ff @(posedge Clock) begin
    if (!nReset) begin
      state_q     <= ST_IDLE;
      result_q    <= '0;
      dest_q      <= '0;
      flags_q     <= '0;
      reg_write_q <= 1'b0;
      valid_q     <= 1'b0;
      rw_pend_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      dest_q      <= dest_d;
      flags_q     <= flags_d;
      reg_write_q <= reg_write_d;
      valid_q     <= valid_d;
      rw_pend_q   <= rw_pend_d;
    end
  end
  assign Result   = result_q;
  assign Dest     = dest_q;
  assign Flags    = flags_q;
  assign RegWrite = reg_write_q;
  assign Valid    = valid_q;
  assign Busy     = busy;
endmodule
